dac7611_scheduler: RTL and testbench

Round-robin scheduler that shares one DAC7611 serial port between `N_REQ` requesters. Each requester presents a 12-bit code with a level request. The block grants one requester at a time, shifts that code MSB-first on CLK/SDI, pulses LD low to latch it, then acknowledges the requester. It sits between the waveform/host sources and the DAC7611 package pins 3/4/5, and replaces the hard-coded single-code frame generator.

---
 rtl/dac7611_pkg.sv | 17 +
 rtl/dac7611_frame.sv | 122 ++++++++++++
 rtl/dac7611_scheduler.sv | 126 ++++++++++++
 tb/tb_dac7611_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dac7611_pkg.sv
// Shared constants and state encoding for the DAC7611 serial-port scheduler.
package dac7611_pkg;

    localparam int DAC_W   = 12;
    localparam int SUB_CYC = 4;
    localparam int GAP_CYC = 2;
    localparam int LD_CYC  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_GAP   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_ACK   = 3'd4
    } dac_state_e;

endpackage

// File: rtl/dac7611_frame.sv
// One DAC7611 frame: 12 bits MSB-first on CLK/SDI, a short gap, then an LD pulse.
// Pin levels are registered from the next-state values so they line up with the state.
module dac7611_frame
    import dac7611_pkg::*;
(
    input  logic             clk_X4,
    input  logic             rst,
    input  logic             start,
    input  logic [DAC_W-1:0] data,
    output logic             done,
    output logic             clk_pin,
    output logic             sdi_pin,
    output logic             ld_pin
);

    localparam logic [1:0] SUB_LAST = 2'(SUB_CYC - 1);
    localparam logic [1:0] SUB_HALF = 2'(SUB_CYC / 2);
    localparam logic [3:0] BIT_LAST = 4'(DAC_W - 1);
    localparam logic [1:0] GAP_LAST = 2'(GAP_CYC - 1);
    localparam logic [1:0] LD_LAST  = 2'(LD_CYC - 1);

    dac_state_e       state_q, state_d;
    logic [DAC_W-1:0] shreg_q, shreg_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       sub_cnt_q, sub_cnt_d;
    logic             clk_pin_q, clk_pin_d;
    logic             sdi_pin_q, sdi_pin_d;
    logic             ld_pin_q, ld_pin_d;

    // Sequencer; sub_cnt doubles as the GAP and LOAD cycle counter.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sub_cnt_d = sub_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = data;
                    bit_cnt_d = 4'd0;
                    sub_cnt_d = 2'd0;
                end
            end
            ST_SHIFT: begin
                if (sub_cnt_q == SUB_LAST) begin
                    sub_cnt_d = 2'd0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = ST_GAP;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    sub_cnt_d = sub_cnt_q + 2'd1;
                end
            end
            ST_GAP: begin
                if (sub_cnt_q == GAP_LAST) begin
                    state_d   = ST_LOAD;
                    sub_cnt_d = 2'd0;
                end else begin
                    sub_cnt_d = sub_cnt_q + 2'd1;
                end
            end
            ST_LOAD: begin
                if (sub_cnt_q == LD_LAST) begin
                    state_d   = ST_IDLE;
                    sub_cnt_d = 2'd0;
                end else begin
                    sub_cnt_d = sub_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // CLK rises mid-bit so the DAC samples a settled SDI.
        clk_pin_d = 1'b1;
        sdi_pin_d = 1'b0;
        ld_pin_d  = 1'b1;
        case (state_d)
            ST_SHIFT: begin
                clk_pin_d = (sub_cnt_d >= SUB_HALF);
                sdi_pin_d = shreg_d[BIT_LAST - bit_cnt_d];
            end
            ST_LOAD: begin
                ld_pin_d = 1'b0;
            end
            default: begin
                ld_pin_d = 1'b1;
            end
        endcase
    end

    always_ff @(negedge clk_X4) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= {DAC_W{1'b0}};
            bit_cnt_q <= 4'd0;
            sub_cnt_q <= 2'd0;
            clk_pin_q <= 1'b1;
            sdi_pin_q <= 1'b0;
            ld_pin_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sub_cnt_q <= sub_cnt_d;
            clk_pin_q <= clk_pin_d;
            sdi_pin_q <= sdi_pin_d;
            ld_pin_q  <= ld_pin_d;
        end
    end

    assign done    = (state_q == ST_LOAD) && (sub_cnt_q == LD_LAST);
    assign clk_pin = clk_pin_q;
    assign sdi_pin = sdi_pin_q;
    assign ld_pin  = ld_pin_q;

endmodule

// File: rtl/dac7611_scheduler.sv
// Round-robin arbiter sharing one DAC7611 serial port among N_REQ requesters.
// The granted code is captured at the grant edge; ack pulses once the LD pulse ends.
module dac7611_scheduler
    import dac7611_pkg::*;
#(
    parameter int N_REQ = 4
)(
    input  logic                   clk_X4,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DAC_W-1:0] code,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   CLK_3,
    output logic                   SDI_4,
    output logic                   LD_5
);

    dac_state_e       state_q, state_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       grant_id_q, grant_id_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [2:0]       sel_id;
    logic [DAC_W-1:0] sel_code;
    logic             start;
    logic             frame_done;

    // Round-robin search starting just after the last acknowledged requester.
    always_comb begin
        int cand;
        found    = 1'b0;
        sel_id   = 3'd0;
        sel_code = {DAC_W{1'b0}};
        cand     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end else begin
                cand = cand;
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && (cand == j) && req[j]) begin
                    found    = 1'b1;
                    sel_id   = 3'(j);
                    sel_code = code[j*DAC_W +: DAC_W];
                end else begin
                    found    = found;
                end
            end
        end
    end

    // ACK is the single cycle after LOAD; the grant that ends it lands on the
    // following edge, which keeps the grant-to-grant period at 55 cycles.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        ack_d      = {N_REQ{1'b0}};
        start      = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACK: begin
                if (enable && found) begin
                    start      = 1'b1;
                    grant_id_d = sel_id;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (frame_done) begin
                    state_d  = ST_ACK;
                    rr_ptr_d = grant_id_q;
                    for (int j = 0; j < N_REQ; j++) begin
                        ack_d[j] = (grant_id_q == 3'(j));
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(negedge clk_X4) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 3'(N_REQ - 1);
            grant_id_q <= 3'd0;
            ack_q      <= {N_REQ{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    dac7611_frame u_frame (
        .clk_X4  (clk_X4),
        .rst     (rst),
        .start   (start),
        .data    (sel_code),
        .done    (frame_done),
        .clk_pin (CLK_3),
        .sdi_pin (SDI_4),
        .ld_pin  (LD_5)
    );

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_dac7611_scheduler.sv
// Directed plus randomized bench for dac7611_scheduler against a frame-level model.
module tb_dac7611_scheduler;

    logic        clk_X4 = 1'b1;
    logic        rst;
    logic        enable;
    logic [3:0]  req;
    logic [11:0] codes [4];
    logic [47:0] code_w;
    logic [3:0]  ack;
    logic        busy;
    logic [2:0]  grant_id;
    logic        CLK_3, SDI_4, LD_5;

    int tests = 0;
    int fails = 0;
    int ptr;
    int last_gid;

    always #5 clk_X4 = ~clk_X4;

    assign code_w = {codes[3], codes[2], codes[1], codes[0]};

    dac7611_scheduler #(.N_REQ(4)) dut (
        .clk_X4   (clk_X4),
        .rst      (rst),
        .enable   (enable),
        .req      (req),
        .code     (code_w),
        .ack      (ack),
        .busy     (busy),
        .grant_id (grant_id),
        .CLK_3    (CLK_3),
        .SDI_4    (SDI_4),
        .LD_5     (LD_5)
    );

    function automatic logic [15:0] pins_now();
        return {5'd0, CLK_3, SDI_4, LD_5, busy, grant_id, ack};
    endfunction

    function automatic logic [15:0] exp_vec(input logic c, input logic s, input logic l,
                                            input logic b, input logic [2:0] g,
                                            input logic [3:0] a);
        return {5'd0, c, s, l, b, g, a};
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_X4);
            chk($sformatf("%s i%0d", tag, i), pins_now(),
                exp_vec(1'b1, 1'b0, 1'b1, 1'b0, 3'(last_gid), 4'b0000));
        end
    endtask

    // mode: 0 none, 1 invert granted code, 2 drop granted req, 3 reset, 4 scramble codes
    task automatic run_frame(input string tag, input int mode, input int mut_c);
        int          id;
        logic [11:0] c_exp;
        logic        e_clk, e_sdi, e_ld;
        logic [3:0]  e_ack;
        id = pick(req, ptr);
        if (id < 0) begin
            tests++;
            fails++;
            $display("FAIL %s no requester to grant observed=none expected=one", tag);
            return;
        end
        c_exp    = codes[id];
        last_gid = id;
        for (int c = 0; c < 55; c++) begin
            @(posedge clk_X4);
            e_clk = (c >= 48) || ((c % 4) >= 2);
            e_sdi = (c < 48) ? c_exp[11 - c / 4] : 1'b0;
            e_ld  = !((c >= 50) && (c <= 53));
            e_ack = (c == 54) ? (4'b0001 << id) : 4'b0000;
            chk($sformatf("%s c%0d", tag, c), pins_now(),
                exp_vec(e_clk, e_sdi, e_ld, 1'b1, 3'(id), e_ack));
            if (c == mut_c) begin
                case (mode)
                    1: codes[id] = ~codes[id];
                    2: req[id] = 1'b0;
                    3: begin
                        rst = 1'b1;
                        return;
                    end
                    4: for (int j = 0; j < 4; j++) codes[j] = 12'($urandom);
                    default: ;
                endcase
            end
        end
        ptr = id;
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        req      = 4'b0000;
        for (int j = 0; j < 4; j++) codes[j] = 12'd0;
        ptr      = 3;
        last_gid = 0;
        repeat (3) @(posedge clk_X4);
        chk("reset", pins_now(), exp_vec(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0000));
        rst    = 1'b0;
        enable = 1'b1;
        idle_chk(2, "idle");

        // All four held: 0,1,2,3,0 back-to-back
        codes[0] = 12'h001; codes[1] = 12'h002; codes[2] = 12'h004; codes[3] = 12'h008;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) run_frame($sformatf("rr%0d", i), 0, -1);
        req = 4'b0000;
        idle_chk(2, "rr_idle");

        codes[0] = 12'hA5C;
        req = 4'b0001;
        run_frame("a5c", 0, -1);
        req = 4'b0000;
        idle_chk(2, "a5c_after");

        codes[0] = 12'h800;
        req = 4'b0001;
        run_frame("hold", 1, 0);
        req = 4'b0000;
        idle_chk(1, "hold_after");

        // Reset during a frame to requester 3
        codes[3] = 12'hC3A;
        req = 4'b1000;
        run_frame("rst", 3, 19);
        @(posedge clk_X4);
        ptr      = 3;
        last_gid = 0;
        chk("rst_pins", pins_now(), exp_vec(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0000));
        rst = 1'b0;
        req = 4'b0000;
        idle_chk(4, "post_rst");
        for (int j = 0; j < 4; j++) codes[j] = 12'($urandom);
        req = 4'b1111;
        run_frame("after_rst", 0, -1);
        req = 4'b0000;

        enable = 1'b0;
        req = 4'b0100;
        idle_chk(5, "en_low");
        enable = 1'b1;
        run_frame("en_high", 0, -1);
        req = 4'b0000;

        codes[1] = 12'h3C5;
        req = 4'b0010;
        run_frame("drop", 2, 9);
        idle_chk(1, "drop_after");

        for (int it = 0; it < 20; it++) begin
            req = 4'($urandom_range(1, 15));
            for (int j = 0; j < 4; j++) codes[j] = 12'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                idle_chk(int'($urandom_range(1, 3)), $sformatf("rnd_en%0d", it));
                enable = 1'b1;
            end
            run_frame($sformatf("rnd%0d", it), 4, int'($urandom_range(0, 53)));
            if ((it % 5) == 4) begin
                req = 4'b0000;
                idle_chk(2, $sformatf("rnd_idle%0d", it));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
